parking_lot_core_n: RTL

Parametrised parking-garage controller: one elevator serving an entrance at floor 0 and FLOORS parking floors, each with one SUV slot and one sedan slot. It generalises the 7-floor parking_lot_top datapath to N floors. It adds a request FIFO so requests arriving while the elevator is busy are queued. It also adds timestamp-based fees and per-floor leakage lockout. The testbench-facing outputs (parked slots, moving, fee, occupancy) are kept compatible.

---
 rtl/parking_lot_core_n_if.sv | 39 +++
 rtl/parking_lot_core_n.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_core_n_if.sv
// Request and status bundle between a parking_lot_core_n controller and its host.
// The host drives requests/leakage on the master side; the controller reports on the slave side.
interface parking_lot_core_n_if #(
  parameter int FLOORS = 7,
  parameter int FEE_W  = 8
) ();
  localparam int FW = $clog2(FLOORS + 1);

  logic [15:0]          license_plate;
  logic                 in_mode;
  logic                 out_mode;
  logic                 leakage;
  logic [FW-1:0]        leakage_floor;
  logic                 req_ready;
  logic                 overflow;
  logic                 reject;
  logic                 done;
  logic [32*FLOORS-1:0] parked;
  logic [FW-1:0]        current_floor;
  logic [15:0]          moving;
  logic                 plate_type;
  logic [FEE_W-1:0]     fee;
  logic [FW-1:0]        empty_suv;
  logic [FW-1:0]        empty_sedan;
  logic                 full_suv;
  logic                 full_sedan;

  modport master (
    output license_plate, in_mode, out_mode, leakage, leakage_floor,
    input  req_ready, overflow, reject, done, parked, current_floor, moving,
           plate_type, fee, empty_suv, empty_sedan, full_suv, full_sedan
  );

  modport slave (
    input  license_plate, in_mode, out_mode, leakage, leakage_floor,
    output req_ready, overflow, reject, done, parked, current_floor, moving,
           plate_type, fee, empty_suv, empty_sedan, full_suv, full_sedan
  );
endinterface

// File: rtl/parking_lot_core_n.sv
// N-floor parking garage controller: request FIFO, single elevator FSM, slot
// allocation with per-floor flood lockout, and timestamp-based exit fees.
module parking_lot_core_n #(
  parameter int FLOORS     = 7,
  parameter int QDEPTH     = 4,
  parameter int TS_W       = 16,
  parameter int FEE_W      = 8,
  parameter int FEE_RATE   = 1,
  parameter int SUV_THRESH = 8
) (
  input logic                 clock,
  input logic                 reset,
  parking_lot_core_n_if.slave bus
);
  localparam int FW = $clog2(FLOORS + 1);
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = TS_W + 32;
  localparam logic [3:0]    SUV_T   = 4'(SUV_THRESH);
  localparam logic [PW-1:0] RATE    = PW'(FEE_RATE);
  localparam logic [PW-1:0] FEE_MAX = PW'({FEE_W{1'b1}});
  localparam logic [CW-1:0] QFULL   = CW'(QDEPTH);
  localparam logic [FW-1:0] FTOP    = FW'(FLOORS);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_GO_PICK, S_GO_DROP} state_t;

  state_t r_state, w_state_nx;

  logic [15:0]     r_suv      [1:FLOORS];
  logic [15:0]     r_sedan    [1:FLOORS];
  logic [TS_W-1:0] r_ts_suv   [1:FLOORS];
  logic [TS_W-1:0] r_ts_sedan [1:FLOORS];
  logic [FLOORS:1] r_flood;

  logic [16:0]   r_fifo [QDEPTH];
  logic [QW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          r_req_ready, r_overflow;

  logic [16:0]      r_req;
  logic [FW-1:0]    r_pick, r_drop, r_floor;
  logic             r_slot_suv;
  logic [TS_W-1:0]  r_entry_ts, r_ts;
  logic [15:0]      r_moving;
  logic             r_plate_type, r_reject, r_done;
  logic [FEE_W-1:0] r_fee;
  logic [FW-1:0]    r_empty_suv, r_empty_sedan;
  logic             r_full_suv, r_full_sedan;

  logic          w_valid, w_push, w_pop, w_reject, w_accept, w_load, w_unload;
  logic [CW-1:0] w_count_nx;
  logic [15:0]   w_req_plate;
  logic          w_req_out, w_req_suv;
  logic          w_found, w_found_suv;
  logic [FW-1:0] w_found_floor, w_free_floor, w_cnt_suv, w_cnt_sedan;
  logic [FW-1:0] w_target, w_step;
  logic [TS_W-1:0]  w_dt;
  logic [PW-1:0]    w_prod;
  logic [FEE_W-1:0] w_fee;

  assign w_valid     = (bus.in_mode ^ bus.out_mode) && (bus.license_plate != '0);
  assign w_push      = w_valid && r_req_ready;
  assign w_count_nx  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_req_plate = r_req[15:0];
  assign w_req_out   = r_req[16];
  assign w_req_suv   = (w_req_plate[15:12] >= SUV_T);

  // Plate lookup, lowest free allocatable floor, and free-slot counts.
  always_comb begin
    w_found       = 1'b0;
    w_found_suv   = 1'b0;
    w_found_floor = '0;
    w_free_floor  = '0;
    w_cnt_suv     = '0;
    w_cnt_sedan   = '0;
    for (int unsigned f = 1; f <= FLOORS; f++) begin
      if (r_suv[f] == w_req_plate) begin
        w_found       = 1'b1;
        w_found_suv   = 1'b1;
        w_found_floor = FW'(f);
      end else if (r_sedan[f] == w_req_plate) begin
        w_found       = 1'b1;
        w_found_suv   = 1'b0;
        w_found_floor = FW'(f);
      end
      if (!r_flood[f]) begin
        if (r_suv[f] == '0)   w_cnt_suv   = w_cnt_suv + FW'(1);
        if (r_sedan[f] == '0) w_cnt_sedan = w_cnt_sedan + FW'(1);
        if ((w_free_floor == '0) &&
            (w_req_suv ? (r_suv[f] == '0) : (r_sedan[f] == '0)))
          w_free_floor = FW'(f);
      end
    end
  end

  assign w_target = (r_state == S_GO_PICK) ? r_pick : r_drop;
  assign w_step   = (r_floor < w_target) ? r_floor + FW'(1) :
                    (r_floor > w_target) ? r_floor - FW'(1) : r_floor;

  assign w_dt   = r_ts - r_entry_ts;
  assign w_prod = PW'(w_dt) * RATE;
  assign w_fee  = (w_prod > FEE_MAX) ? '1 : w_prod[FEE_W-1:0];

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_reject   = 1'b0;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_unload   = 1'b0;
    case (r_state)
      S_IDLE: if (r_count != '0) begin
        w_pop      = 1'b1;
        w_state_nx = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (w_req_out ? !w_found : (w_found || (w_free_floor == '0))) begin
          w_reject   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_accept   = 1'b1;
          w_state_nx = S_GO_PICK;
        end
      end
      S_GO_PICK: if (r_floor == r_pick) begin
        w_load     = 1'b1;
        w_state_nx = S_GO_DROP;
      end
      // The final step onto the drop floor also unloads, so arrival and done share one edge.
      S_GO_DROP: if ((r_floor == r_drop) || (w_step == r_drop)) begin
        w_unload   = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned f = 1; f <= FLOORS; f++) begin
        r_suv[f]      <= '0;
        r_sedan[f]    <= '0;
        r_ts_suv[f]   <= '0;
        r_ts_sedan[f] <= '0;
      end
      for (int unsigned i = 0; i < QDEPTH; i++) r_fifo[i] <= '0;
      r_flood       <= '0;
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_req_ready   <= 1'b1;
      r_overflow    <= 1'b0;
      r_req         <= '0;
      r_pick        <= '0;
      r_drop        <= '0;
      r_floor       <= '0;
      r_slot_suv    <= 1'b0;
      r_entry_ts    <= '0;
      r_ts          <= '0;
      r_moving      <= '0;
      r_plate_type  <= 1'b0;
      r_reject      <= 1'b0;
      r_done        <= 1'b0;
      r_fee         <= '0;
      r_empty_suv   <= FTOP;
      r_empty_sedan <= FTOP;
      r_full_suv    <= 1'b0;
      r_full_sedan  <= 1'b0;
    end else begin
      r_ts        <= r_ts + TS_W'(1);
      r_overflow  <= w_valid && !r_req_ready;
      r_count     <= w_count_nx;
      r_req_ready <= (w_count_nx != QFULL);
      r_reject    <= w_reject;
      r_done      <= w_unload;

      if (w_push) begin
        r_fifo[r_wr] <= {bus.out_mode, bus.license_plate};
        r_wr         <= (r_wr == QW'(QDEPTH - 1)) ? '0 : r_wr + QW'(1);
      end
      if (w_pop) begin
        r_req <= r_fifo[r_rd];
        r_rd  <= (r_rd == QW'(QDEPTH - 1)) ? '0 : r_rd + QW'(1);
      end

      if (bus.leakage && (bus.leakage_floor != '0) && (bus.leakage_floor <= FTOP))
        r_flood[bus.leakage_floor] <= 1'b1;

      if (w_accept) begin
        if (w_req_out) begin
          r_pick     <= w_found_floor;
          r_drop     <= '0;
          r_slot_suv <= w_found_suv;
        end else begin
          r_pick     <= '0;
          r_drop     <= w_free_floor;
          r_slot_suv <= w_req_suv;
        end
      end

      if (((r_state == S_GO_PICK) && !w_load) || (r_state == S_GO_DROP))
        r_floor <= w_step;

      if (w_load) begin
        r_moving     <= w_req_plate;
        r_plate_type <= w_req_suv;
        if (w_req_out) begin
          r_entry_ts <= r_slot_suv ? r_ts_suv[r_pick] : r_ts_sedan[r_pick];
          if (r_slot_suv) r_suv[r_pick]   <= '0;
          else            r_sedan[r_pick] <= '0;
        end
      end

      if (w_unload) begin
        r_moving <= '0;
        if (w_req_out) begin
          r_fee <= w_fee;
        end else if (r_slot_suv) begin
          r_suv[r_drop]    <= w_req_plate;
          r_ts_suv[r_drop] <= r_ts;
        end else begin
          r_sedan[r_drop]    <= w_req_plate;
          r_ts_sedan[r_drop] <= r_ts;
        end
      end

      r_empty_suv   <= w_cnt_suv;
      r_empty_sedan <= w_cnt_sedan;
      r_full_suv    <= (w_cnt_suv == '0);
      r_full_sedan  <= (w_cnt_sedan == '0);
    end
  end

  for (genvar g = 1; g <= FLOORS; g++) begin : g_parked
    assign bus.parked[(g-1)*32 +: 32] = {r_suv[g], r_sedan[g]};
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.overflow      = r_overflow;
  assign bus.reject        = r_reject;
  assign bus.done          = r_done;
  assign bus.current_floor = r_floor;
  assign bus.moving        = r_moving;
  assign bus.plate_type    = r_plate_type;
  assign bus.fee           = r_fee;
  assign bus.empty_suv     = r_empty_suv;
  assign bus.empty_sedan   = r_empty_sedan;
  assign bus.full_suv      = r_full_suv;
  assign bus.full_sedan    = r_full_sedan;
endmodule
